// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with start-edge detection, mid-bit sampling, optional even parity,
// 1/2 stop bits and a single-entry valid/ready holding register.
module uart_rx_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_i,
   output logic        busy_o,
   input  logic        cfg_en_i,
   input  logic [15:0] cfg_div_i,
   input  logic        cfg_parity_en_i,
   input  logic [1:0]  cfg_bits_i,
   input  logic        cfg_stop_bits_i,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic        err_parity_o,
   output logic        err_frame_o,
   output logic        err_overrun_o
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP_FIRST, STOP_LAST} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sync;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic rx_s, rx_prev, full, half, last_bit, complete, par_acc, par_err, frm_err, free;
   assign rx_s     = sync[SYNC_STAGES-1];
   assign full     = cnt == cfg_div_i;
   assign half     = cnt == (cfg_div_i >> 1);
   assign last_bit = bit_cnt == {1'b0, cfg_bits_i} + 3'd4;
   assign free     = !rx_valid_o || rx_ready_i;
   assign busy_o   = state != IDLE;
   always_comb begin
      state_n  = state;
      complete = 1'b0;
      case (state)
         IDLE:       if (rx_prev && !rx_s) state_n = START;
         START:      if (half) state_n = rx_s ? IDLE : DATA;
         DATA:       if (full && last_bit) state_n = cfg_parity_en_i ? PARITY : STOP_FIRST;
         PARITY:     if (full) state_n = STOP_FIRST;
         STOP_FIRST: if (full) begin
            state_n  = cfg_stop_bits_i ? STOP_LAST : IDLE;
            complete = !cfg_stop_bits_i;
         end
         STOP_LAST:  if (full) begin
            state_n  = IDLE;
            complete = 1'b1;
         end
         default:    state_n = IDLE;
      endcase
      if (!cfg_en_i) begin
         state_n  = IDLE;
         complete = 1'b0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync          <= '1;
         rx_prev       <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_acc       <= 1'b0;
         par_err       <= 1'b0;
         frm_err       <= 1'b0;
         rx_data_o     <= '0;
         rx_valid_o    <= 1'b0;
         err_parity_o  <= 1'b0;
         err_frame_o   <= 1'b0;
         err_overrun_o <= 1'b0;
      end else begin
         sync          <= {sync[SYNC_STAGES-2:0], rx_i};
         rx_prev       <= rx_s;
         state         <= state_n;
         cnt           <= (state_n != state || full) ? '0 : cnt + 16'd1;
         err_parity_o  <= 1'b0;
         err_frame_o   <= 1'b0;
         err_overrun_o <= 1'b0;
         if (state == START && state_n == DATA) begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
         end
         if (state == DATA && full) begin
            shreg   <= {rx_s, shreg[7:1]};
            par_acc <= par_acc ^ rx_s;
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (state == PARITY && full) par_err <= par_acc ^ rx_s;
         if (state == STOP_FIRST && full) frm_err <= !rx_s;
         // The final stop sample is folded in combinationally so the byte lands as busy_o drops.
         if (complete && free) begin
            rx_data_o    <= shreg >> (2'd3 - cfg_bits_i);
            rx_valid_o   <= 1'b1;
            err_parity_o <= par_err;
            err_frame_o  <= frm_err | !rx_s;
         end else if (complete) begin
            err_overrun_o <= 1'b1;
         end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with a queue scoreboard checked by an independent monitor.
module tb_uart_rx_core;
   logic clk = 0, rst_i = 1, rx_i = 1, cfg_en_i = 1, cfg_parity_en_i = 0, cfg_stop_bits_i = 0, rx_ready_i = 1;
   logic [15:0] cfg_div_i = 16'd15;
   logic [1:0]  cfg_bits_i = 2'd3;
   logic [7:0]  rx_data_o;
   logic        busy_o, rx_valid_o, err_parity_o, err_frame_o, err_overrun_o;
   typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
   exp_t exp_q[$];
   int compared = 0, mismatched = 0, exp_ovr = 0, cyc = 0, fall_cyc = 0, load_cyc = -1000, lat = 0;
   logic pv = 0, pr = 0;

   uart_rx_core #(.SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .busy_o(busy_o), .cfg_en_i(cfg_en_i),
      .cfg_div_i(cfg_div_i), .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i),
      .cfg_stop_bits_i(cfg_stop_bits_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
      .err_overrun_o(err_overrun_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(string n, int act, int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", n, act, req, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_i) begin
         if (rx_valid_o && (!pv || pr)) begin
            load_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rx_data", rx_data_o, e.d);
               chk("err_parity", err_parity_o, e.pe);
               chk("err_frame", err_frame_o, e.fe);
               chk("busy_at_load", busy_o, 0);
            end
         end else if (err_parity_o || err_frame_o) chk("err_without_load", 1, 0);
         if (err_overrun_o) begin
            chk("err_overrun", exp_ovr > 0, 1);
            if (exp_ovr > 0) exp_ovr--;
         end
      end
      pv = rx_valid_o;
      pr = rx_ready_i;
   end

   task automatic idle(input int n);
      rx_i = 1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v);
      rx_i = v;
      repeat (int'(cfg_div_i) + 1) @(posedge clk);
      #1;
   endtask

   // par: 0 none, 1 correct even parity, 2 inverted; abort >= 0 stops mid data bit 'abort'
   task automatic send(input logic [7:0] d, input int nb, input int par, input int ns, input logic stop0, input int abort);
      logic p;
      p = 0;
      fall_cyc = cyc;
      drive(0);
      for (int i = 0; i < nb; i++) begin
         if (i == abort) begin
            rx_i = d[i];
            repeat ((int'(cfg_div_i) + 1) / 2) @(posedge clk);
            #1;
            return;
         end
         p ^= d[i];
         drive(d[i]);
      end
      if (par != 0) drive(par == 1 ? p : ~p);
      drive(stop0);
      if (ns == 2) drive(1);
   endtask

   task automatic cfg(input int div, input logic [1:0] bits, input logic pen, input logic st2);
      cfg_div_i = 16'(div);
      cfg_bits_i = bits;
      cfg_parity_en_i = pen;
      cfg_stop_bits_i = st2;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_i = 0;
      chk("reset_rx_data", rx_data_o, 0);
      chk("reset_rx_valid", rx_valid_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_errs", {err_parity_o, err_frame_o, err_overrun_o}, 0);
      idle(5);
      // 8N1, div 15
      cfg(15, 2'd3, 0, 0);
      exp_q.push_back('{8'hA5, 0, 0});
      send(8'hA5, 8, 0, 1, 1, -1);
      lat = load_cyc - fall_cyc;
      chk("latency_in_window", (lat >= 152 && lat <= 156), 1);
      idle(20);
      // 7E2, div 9
      cfg(9, 2'd2, 1, 1);
      exp_q.push_back('{8'h5A, 0, 0});
      send(8'h5A, 7, 1, 2, 1, -1);
      idle(5);
      exp_q.push_back('{8'h33, 0, 0});
      send(8'h33, 7, 1, 2, 1, -1);
      idle(5);
      exp_q.push_back('{8'h33, 1, 0});
      send(8'h33, 7, 2, 2, 1, -1);
      idle(20);
      // 5N1, div 7: bad stop bit, then a glitch
      cfg(7, 2'd0, 0, 0);
      exp_q.push_back('{8'h1F, 0, 1});
      send(8'h1F, 5, 0, 1, 0, -1);
      idle(20);
      rx_i = 0;
      repeat (3) @(posedge clk);
      #1 rx_i = 1;
      idle(40);
      chk("glitch_busy", busy_o, 0);
      chk("glitch_valid", rx_valid_o, 0);
      // overrun, then ready raised exactly on the completion edge
      cfg(15, 2'd3, 0, 0);
      rx_ready_i = 0;
      exp_q.push_back('{8'h11, 0, 0});
      send(8'h11, 8, 0, 1, 1, -1);
      idle(5);
      exp_ovr++;
      send(8'h22, 8, 0, 1, 1, -1);
      idle(5);
      chk("held_data", rx_data_o, 8'h11);
      exp_q.push_back('{8'h33, 0, 0});
      fork
         send(8'h33, 8, 0, 1, 1, -1);
         begin
            repeat (lat - 1) @(posedge clk);
            #1 rx_ready_i = 1;
            @(posedge clk);
            #1 rx_ready_i = 0;
         end
      join
      idle(5);
      chk("handoff_data", rx_data_o, 8'h33);
      chk("handoff_valid", rx_valid_o, 1);
      rx_ready_i = 1;
      idle(5);
      chk("drained_valid", rx_valid_o, 0);
      // back-to-back 8N1
      exp_q.push_back('{8'hC3, 0, 0});
      exp_q.push_back('{8'h3C, 0, 0});
      send(8'hC3, 8, 0, 1, 1, -1);
      send(8'h3C, 8, 0, 1, 1, -1);
      idle(20);
      // reset at bit 4
      send(8'h96, 8, 0, 1, 1, 4);
      chk("busy_before_reset", busy_o, 1);
      rst_i = 1;
      rx_i = 1;
      @(posedge clk);
      #1 rst_i = 0;
      chk("abort_rst_busy", busy_o, 0);
      chk("abort_rst_valid", rx_valid_o, 0);
      idle(200);
      exp_q.push_back('{8'h4B, 0, 0});
      send(8'h4B, 8, 0, 1, 1, -1);
      idle(20);
      // enable drop at bit 4
      send(8'h96, 8, 0, 1, 1, 4);
      cfg_en_i = 0;
      rx_i = 1;
      @(posedge clk);
      #1;
      chk("abort_en_busy", busy_o, 0);
      idle(3);
      cfg_en_i = 1;
      idle(200);
      chk("abort_en_valid", rx_valid_o, 0);
      exp_q.push_back('{8'h69, 0, 0});
      send(8'h69, 8, 0, 1, 1, -1);
      idle(30);
      chk("pending_frames", exp_q.size(), 0);
      chk("pending_overruns", exp_ovr, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
